// File: rtl/round_decode_poly_pkg.sv
// Shared definitions for the rounded-polynomial decoder.
// State encoding, default widths and the sntrup modulus.
package round_decode_poly_pkg;

    localparam int DEF_W      = 13;
    localparam int DEF_ADDR_W = 10;
    localparam int SNTRUP_Q   = 4591;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_CALC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/round_decode_poly_if.sv
// Control and RAM bus of the rounded-polynomial decoder.
// master = requester/RAM side, slave = decoder side.
interface round_decode_poly_if
    import round_decode_poly_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int W      = DEF_W
);

    logic              start;
    logic [W-1:0]      q;
    logic [ADDR_W-1:0] p_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, q, p_len, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  busy, done, err
    );

    modport slave (
        input  start, q, p_len, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output busy, done, err
    );

endinterface

// File: rtl/round_decode_poly_coef.sv
// Per-coefficient arithmetic: index r -> 3r - (q-1)/2 mod q.
// Holds the fetched index and the registered result.
module round_decode_coef
    import round_decode_poly_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_r,
    input  logic [W-1:0] r_in,
    input  logic         calc_en,
    input  logic [W-1:0] q,
    input  logic [W-1:0] limit,
    output logic [W-1:0] result,
    output logic         range_err
);

    logic [W-1:0] r_q, r_d;
    logic [W-1:0] res_q, res_d;
    logic [W+1:0] t;
    logic [W+1:0] h;
    logic [W+1:0] diff;

    // Datapath: triple the index, recentre by h, fold into [0,q).
    always_comb begin
        r_d       = r_q;
        res_d     = res_q;
        t         = {2'b00, r_q} + {1'b0, r_q, 1'b0};
        h         = {2'b00, (q - W'(1)) >> 1};
        diff      = t - h;
        range_err = (r_q > limit);
        if (load_r) begin
            r_d = r_in;
        end
        if (calc_en) begin
            if (range_err) begin
                res_d = '0;
            end else if (t >= h) begin
                res_d = diff[W-1:0];
            end else begin
                diff  = diff + {2'b00, q};
                res_d = diff[W-1:0];
            end
        end
    end

    // Index and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            res_q <= '0;
        end else begin
            r_q   <= r_d;
            res_q <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/round_decode_poly.sv
// Rounded-polynomial decoder: reads indices, writes coefficients.
// Four cycles per coefficient: FETCH, WAIT, CALC, WRITE.
module round_decode_poly
    import round_decode_poly_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int W      = DEF_W
) (
    input  logic                clk,
    input  logic                rst,
    round_decode_poly_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] plen_q, plen_d;
    logic [W-1:0]      q_q, q_d;
    logic [W-1:0]      limit_q, limit_d;
    logic              err_q, err_d;
    logic              load_r;
    logic              calc_en;
    logic [W-1:0]      result;
    logic              range_err;

    round_decode_coef #(
        .W (W)
    ) u_coef (
        .clk       (clk),
        .rst       (rst),
        .load_r    (load_r),
        .r_in      (bus.rd_data),
        .calc_en   (calc_en),
        .q         (q_q),
        .limit     (limit_q),
        .result    (result),
        .range_err (range_err)
    );

    // Next-state logic; limit (q-1)/3 is latched once at start.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        plen_d  = plen_q;
        q_d     = q_q;
        limit_d = limit_q;
        err_d   = err_q;
        load_r  = 1'b0;
        calc_en = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    q_d     = bus.q;
                    plen_d  = bus.p_len;
                    limit_d = (bus.q - W'(1)) / W'(3);
                    idx_d   = '0;
                    err_d   = 1'b0;
                    if (bus.p_len != '0) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                load_r  = 1'b1;
                state_d = S_CALC;
            end
            S_CALC: begin
                calc_en = 1'b1;
                if (range_err) begin
                    err_d = 1'b1;
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (idx_q == plen_q - ADDR_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and run-parameter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            plen_q  <= '0;
            q_q     <= '0;
            limit_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            plen_q  <= plen_d;
            q_q     <= q_d;
            limit_q <= limit_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state; buses held at zero when idle.
    always_comb begin
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.busy    = (state_q != S_IDLE);
        bus.done    = (state_q == S_DONE);
        bus.err     = err_q;
        if (state_q == S_FETCH) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = idx_q;
        end
        if (state_q == S_WRITE) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = idx_q;
            bus.wr_data = result;
        end
    end

endmodule

// File: tb/tb_round_decode_poly.sv
// Directed bench for round_decode_poly: vector table plus
// disturb, mid-run reset and full round-trip sequences.
`timescale 1ns/1ps
module tb_round_decode_poly;

    logic clk;
    logic rst;

    round_decode_poly_if #(.ADDR_W(10), .W(13)) bus ();

    round_decode_poly #(.ADDR_W(10), .W(13)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk;
    int n_err;

    logic [12:0] mem [1024];
    int          expw [1024];

    int wa [8192];
    int wd [8192];
    int ra [8192];
    int nw;
    int nr;
    int overlap;
    int ndone;
    int nbusy;

    typedef struct packed {
        logic [12:0] q;
        logic [9:0]  pl;
        logic [12:0] r0, r1, r2, r3;
        logic [12:0] e0, e1, e2, e3;
        logic        err;
    } vec_t;

    vec_t tbl [7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en && nw < 8192) begin
            wa[nw] = int'(bus.wr_addr);
            wd[nw] = int'(bus.wr_data);
            nw++;
        end
        if (bus.rd_en && nr < 8192) begin
            ra[nr] = int'(bus.rd_addr);
            nr++;
        end
        if (bus.rd_en && bus.wr_en) overlap++;
        if (bus.done) ndone++;
        if (bus.busy) nbusy++;
    end

    task automatic chk(input string nm, input string what,
                       input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0d expected %0d",
                     nm, what, act, exp);
        end
    endtask

    function automatic vec_t mk(input int q, input int pl,
        input int r0, input int r1, input int r2, input int r3,
        input int e0, input int e1, input int e2, input int e3,
        input bit err);
        vec_t v;
        v.q = 13'(q);  v.pl = 10'(pl);
        v.r0 = 13'(r0); v.r1 = 13'(r1);
        v.r2 = 13'(r2); v.r3 = 13'(r3);
        v.e0 = 13'(e0); v.e1 = 13'(e1);
        v.e2 = 13'(e2); v.e3 = 13'(e3);
        v.err = err;
        return v;
    endfunction

    task automatic start_run(input int qv, input int pl,
                             input int budget, input bit disturb,
                             output int cyc);
        bus.q     = 13'(qv);
        bus.p_len = 10'(pl);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < budget) begin
            if (disturb && cyc >= 2 && cyc <= 6) begin
                bus.start = 1'b1;
                bus.q     = 13'd13;
                bus.p_len = 10'd1;
            end else begin
                bus.start = 1'b0;
                bus.q     = 13'(qv);
                bus.p_len = 10'(pl);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.q     = 13'(qv);
        bus.p_len = 10'(pl);
    endtask

    task automatic run_check(input string nm, input int qv,
                             input int pl, input bit exp_err,
                             input bit disturb);
        int nw0 = nw;
        int nr0 = nr;
        int nd0 = ndone;
        int nb0 = nbusy;
        int ov0 = overlap;
        int cyc;
        start_run(qv, pl, 4 * pl + 20, disturb, cyc);
        chk(nm, "done", int'(bus.done), 1);
        chk(nm, "latency", cyc, 4 * pl + 1);
        @(posedge clk);
        #1;
        chk(nm, "done_one_cycle", int'(bus.done), 0);
        chk(nm, "busy_end", int'(bus.busy), 0);
        chk(nm, "err", int'(bus.err), int'(exp_err));
        chk(nm, "n_writes", nw - nw0, pl);
        chk(nm, "n_reads", nr - nr0, pl);
        chk(nm, "n_done", ndone - nd0, 1);
        chk(nm, "busy_cycles", nbusy - nb0, 4 * pl + 1);
        chk(nm, "rd_wr_overlap", overlap - ov0, 0);
        for (int i = 0; i < pl && nw0 + i < nw; i++) begin
            chk(nm, $sformatf("wr_addr[%0d]", i), wa[nw0 + i], i);
            chk(nm, $sformatf("wr_data[%0d]", i), wd[nw0 + i], expw[i]);
        end
        for (int i = 0; i < pl && nr0 + i < nr; i++) begin
            chk(nm, $sformatf("rd_addr[%0d]", i), ra[nr0 + i], i);
        end
    endtask

    task automatic load_vec(input vec_t v);
        mem[0] = v.r0; mem[1] = v.r1; mem[2] = v.r2; mem[3] = v.r3;
        expw[0] = int'(v.e0); expw[1] = int'(v.e1);
        expw[2] = int'(v.e2); expw[3] = int'(v.e3);
    endtask

    task automatic chk_idle_zero(input string nm);
        chk(nm, "rd_en", int'(bus.rd_en), 0);
        chk(nm, "rd_addr", int'(bus.rd_addr), 0);
        chk(nm, "wr_en", int'(bus.wr_en), 0);
        chk(nm, "wr_addr", int'(bus.wr_addr), 0);
        chk(nm, "wr_data", int'(bus.wr_data), 0);
        chk(nm, "busy", int'(bus.busy), 0);
        chk(nm, "done", int'(bus.done), 0);
        chk(nm, "err", int'(bus.err), 0);
    endtask

    initial begin
        int cyc;
        int nw0;
        int nr0;
        int nd0;
        int c;
        n_chk = 0; n_err = 0;
        nw = 0; nr = 0; overlap = 0; ndone = 0; nbusy = 0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        bus.start = 1'b0;
        bus.q = 13'd4591;
        bus.p_len = '0;
        bus.rd_data = '0;
        rst = 1'b1;

        tbl[0] = mk(4591, 3, 0, 765, 1530, 0, 2296, 0, 2295, 0, 0);
        tbl[1] = mk(4591, 2, 1531, 1, 0, 0, 0, 2299, 0, 0, 1);
        tbl[2] = mk(4591, 0, 5, 5, 5, 5, 0, 0, 0, 0, 0);
        tbl[3] = mk(7, 4, 0, 1, 2, 3, 4, 0, 3, 0, 1);
        tbl[4] = mk(13, 3, 4, 2, 1, 0, 6, 0, 10, 0, 0);
        tbl[5] = mk(4591, 1, 1530, 0, 0, 0, 2295, 0, 0, 0, 0);
        tbl[6] = mk(4591, 2, 8191, 766, 0, 0, 0, 3, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) begin
            load_vec(tbl[v]);
            run_check($sformatf("vec%0d", v), int'(tbl[v].q),
                      int'(tbl[v].pl), tbl[v].err, 1'b0);
            if (tbl[v].err) begin
                repeat (4) @(posedge clk);
                #1;
                chk($sformatf("vec%0d", v), "err_held",
                    int'(bus.err), 1);
            end
        end

        load_vec(tbl[0]);
        run_check("disturb", 4591, 3, 1'b0, 1'b1);

        mem[0] = 13'd1531; mem[1] = 13'd1; mem[2] = 13'd2;
        mem[3] = 13'd3;    mem[4] = 13'd4;
        nw0 = nw; nr0 = nr; nd0 = ndone;
        bus.q = 13'd4591;
        bus.p_len = 10'd5;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("midrst", "wr_en_before", int'(bus.wr_en), 1);
        chk("midrst", "err_before", int'(bus.err), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_idle_zero("midrst");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst", "n_writes", nw - nw0, 2);
        chk("midrst", "n_reads", nr - nr0, 2);
        chk("midrst", "n_done", ndone - nd0, 0);
        chk("midrst", "busy_after", int'(bus.busy), 0);
        load_vec(tbl[0]);
        run_check("after_rst", 4591, 3, 1'b0, 1'b0);

        for (int i = 0; i < 1023; i++) begin
            mem[i] = 13'(i);
            c = 3 * i - 2295;
            expw[i] = (c < 0) ? c + 4591 : c;
        end
        run_check("trip_lo", 4591, 1023, 1'b0, 1'b0);
        for (int i = 0; i < 508; i++) begin
            mem[i] = 13'(1023 + i);
            c = 3 * (1023 + i) - 2295;
            expw[i] = (c < 0) ? c + 4591 : c;
        end
        run_check("trip_hi", 4591, 508, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/round_decode_poly.md
ROUND_DECODE_POLY -- requirements
Module: round_decode_poly

Interface
REQ-001 Parameter: ADDR_W, default 10, coefficient address width.
REQ-002 Parameter: W, default 13, coefficient width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to decode a polynomial; sampled in IDLE only.
REQ-006 q  in  W  modulus (odd, q mod 3 = 1, e.g. 4591); sampled when start is accepted.
REQ-007 p_len  in  ADDR_W  coefficient count (0..2^ADDR_W-1); sampled when start is accepted.
REQ-008 rd_en  out  1  read strobe to source RAM of rounded indices.
REQ-009 rd_addr  out  ADDR_W  source address.
REQ-010 rd_data  in  W  index r, valid exactly one cycle after rd_en.
REQ-011 wr_en  out  1  write strobe to destination RAM.
REQ-012 wr_addr  out  ADDR_W  destination address, equal to source address of the same coefficient.
REQ-013 wr_data  out  W  decoded coefficient in [0,q).
REQ-014 busy  out  1  high from the cycle after start is accepted through the DONE state.
REQ-015 done  out  1  one-cycle pulse when the polynomial is finished.
REQ-016 err  out  1  sticky range-error flag; cleared on accepted start.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, CALC, WRITE, DONE.
REQ-018 IDLE: start=1 -> latch q, p_len, clear idx and err; go FETCH if p_len>0, else DONE.
REQ-019 FETCH: rd_en=1, rd_addr=idx; next WAIT.
REQ-020 WAIT: capture rd_data into r_reg; next CALC.
REQ-021 CALC: h=(q-1)>>1, t=3*r_reg (W+2 bits); if r_reg>(q-1)/3 -> result 0, err<=1; elif t>=h -> t-h; else t-h+q; register result; next WRITE.
REQ-022 WRITE: wr_en=1, wr_addr=idx, wr_data=result; if idx==p_len-1 -> DONE, else idx+1, FETCH.
REQ-023 DONE: done=1 for exactly one cycle; next IDLE.
REQ-024 Throughput 4 cycles per coefficient; start-to-done = 4*p_len+1 cycles (p_len=0: done in the cycle after start).
REQ-025 start outside IDLE SHALL be ignored; latched q/p_len SHALL NOT change mid-operation.
REQ-026 rd_en and wr_en SHALL never be high in the same cycle; each address is read once and written once, ascending order.
REQ-027 A range error SHALL NOT abort the run; remaining coefficients are still decoded.
REQ-028 (q-1)/3 SHALL be computed once per run into a register (combinational divide-by-constant or one-time sequential divider), not per coefficient.

Reset
REQ-029 rst SHALL force IDLE and clear idx, r_reg, result, err, and all outputs (rd_en, wr_en, busy, done = 0; addresses/data = 0) immediately.
REQ-030 rst mid-run SHALL abandon the run with no further RAM accesses; no done pulse.

Structure
REQ-031 Shared package: state encoding, default W/ADDR_W, sntrup default constant Q=4591.
REQ-032 Sub-module round_decode_coef: registered per-coefficient arithmetic (r, q, limit -> result, range_err); FSM, counter, RAM interface stay in round_decode_poly.

Verification
REQ-033 q=4591, p_len=3, RAM={0,765,1530} -> writes {2296,0,2295} at addresses 0,1,2; err=0; done 13 cycles after start.
REQ-034 q=4591, p_len=2, RAM={1531,1} -> writes {0,2299}; err=1 and held until next start.
REQ-035 p_len=0 -> no rd_en/wr_en; done pulse in the cycle after start; busy high one cycle.
REQ-036 start reasserted and q changed while busy -> ignored; outputs identical to undisturbed run.
REQ-037 rst pulsed after 2nd write of a 5-coefficient run -> all outputs 0 at once, no further accesses; new start then completes full run correctly.
REQ-038 Round trip: every multiple-of-3 coefficient c in [-2295,2295], encoded r=(c+2295)/3 -> wr_data == c mod 4591, matching Round_poly output.
